// File: rtl/oled_pkg.sv
// Shared OLED definitions: panel geometry, the RGB565 pixel type and a few named colours.
package oled_pkg;

  localparam int OLED_W = 96;
  localparam int OLED_H = 64;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t BLACK = 16'h0000;
  localparam rgb565_t WHITE = 16'hFFFF;
  localparam rgb565_t RED   = 16'hF800;
  localparam rgb565_t GREEN = 16'h07E0;
  localparam rgb565_t BLUE  = 16'h001F;

endpackage

// File: rtl/oled_xy_counter.sv
// Scan-position counters that follow the display's pixel requests.
// Produces a one-cycle wrap pulse as the position returns from the last pixel to (0,0).
module oled_xy_counter
  import oled_pkg::*;
#(
  parameter int WIDTH  = OLED_W,
  parameter int HEIGHT = OLED_H
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_begin,
  input  logic       sample_pixel,
  output logic [6:0] x,
  output logic [6:0] y,
  output logic       wrap
);

  // frame_begin outranks sample_pixel so a coincident pulse cannot skip the first pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      x    <= '0;
      y    <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (frame_begin) begin
        x <= '0;
        y <= '0;
      end else if (sample_pixel) begin
        if (x == 7'(WIDTH - 1)) begin
          x <= '0;
          if (y == 7'(HEIGHT - 1)) begin
            y    <= '0;
            wrap <= 1'b1;
          end else begin
            y <= y + 7'd1;
          end
        end else begin
          x <= x + 7'd1;
        end
      end
    end
  end

endmodule

// File: rtl/oled_frame_scanner.sv
// OLED front end: scan counters, pixel_index cross-check, tear-free channel select, frame count.
// Define OLED_BORDER_EN to overlay a BORDER_COLOR frame on the outermost rows and columns.
module oled_frame_scanner
  import oled_pkg::*;
#(
  parameter int      WIDTH        = OLED_W,
  parameter int      HEIGHT       = OLED_H,
  parameter int      N_CH         = 4,
  parameter int      IDX_W        = 13,
  parameter int      SEL_W        = 2,
  parameter int      FCNT_W       = 8,
  parameter rgb565_t BORDER_COLOR = WHITE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_begin,
  input  logic                 sample_pixel,
  input  logic [IDX_W-1:0]     pixel_index,
  input  logic [SEL_W-1:0]     sel,
  input  logic [N_CH*16-1:0]   ch_pixel_data,
  output logic [6:0]           x,
  output logic [6:0]           y,
  output logic [15:0]          pixel_data,
  output logic [SEL_W-1:0]     active_ch,
  output logic [FCNT_W-1:0]    frame_count,
  output logic                 sync_err
);

  logic             scan_wrap;
  logic [IDX_W-1:0] expected_index;
  logic             sel_valid;
  rgb565_t          ch_pixel;
  rgb565_t          next_pixel;

  oled_xy_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_xy (
    .clk         (clk),
    .reset       (reset),
    .frame_begin (frame_begin),
    .sample_pixel(sample_pixel),
    .x           (x),
    .y           (y),
    .wrap        (scan_wrap)
  );

  assign expected_index = IDX_W'(y) * IDX_W'(WIDTH) + IDX_W'(x);
  assign sel_valid      = (int'({1'b0, sel}) < N_CH);
  assign ch_pixel       = ch_pixel_data[16*int'(active_ch) +: 16];

`ifdef OLED_BORDER_EN
  logic on_border;
  assign on_border  = (x == 7'd0) || (x == 7'(WIDTH - 1)) ||
                      (y == 7'd0) || (y == 7'(HEIGHT - 1));
  assign next_pixel = on_border ? BORDER_COLOR : ch_pixel;
`else
  assign next_pixel = ch_pixel;
`endif

  // Channel changes are only taken at frame_begin so a frame is always drawn from one source;
  // the scan wrap pulse is not needed here because pixel_index drives the cross-check.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_data  <= '0;
      active_ch   <= '0;
      frame_count <= '0;
      sync_err    <= 1'b0;
    end else begin
      pixel_data <= next_pixel;
      if (frame_begin) begin
        frame_count <= frame_count + FCNT_W'(1);
        if (sel_valid) active_ch <= sel;
      end
      if (sample_pixel && !frame_begin && (expected_index != pixel_index))
        sync_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_oled_frame_scanner.sv
// Scoreboard bench for oled_frame_scanner (three channels so an out-of-range select can be tried).
// Pixel expectations follow OLED_BORDER_EN the same way the design does.
module tb_oled_frame_scanner;

  localparam int N_CH  = 3;
  localparam int IDX_W = 13;
  localparam int SEL_W = 2;
  localparam int FCNT_W = 8;

  localparam int K_X = 0, K_Y = 1, K_PIX = 2, K_ACT = 3, K_FCNT = 4, K_ERR = 5;

  typedef struct {
    string       name;
    int          kind;
    logic [15:0] exp;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               frame_begin = 1'b0;
  logic               sample_pixel = 1'b0;
  logic [IDX_W-1:0]   pixel_index = '0;
  logic [SEL_W-1:0]   sel = '0;
  logic [N_CH*16-1:0] ch_pixel_data = {16'hF800, 16'h07E0, 16'h001F};
  logic [6:0]         x, y;
  logic [15:0]        pixel_data;
  logic [SEL_W-1:0]   active_ch;
  logic [FCNT_W-1:0]  frame_count;
  logic               sync_err;

  exp_t sb[$];
  exp_t mon_item;
  logic [15:0] mon_actual;
  int checks = 0;
  int failures = 0;

  oled_frame_scanner #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W),
    .SEL_W (SEL_W),
    .FCNT_W(FCNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_begin  (frame_begin),
    .sample_pixel (sample_pixel),
    .pixel_index  (pixel_index),
    .sel          (sel),
    .ch_pixel_data(ch_pixel_data),
    .x            (x),
    .y            (y),
    .pixel_data   (pixel_data),
    .active_ch    (active_ch),
    .frame_count  (frame_count),
    .sync_err     (sync_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] expPix(input int px, input int py, input logic [15:0] ch);
`ifdef OLED_BORDER_EN
    if (px == 0 || px == 95 || py == 0 || py == 63) return 16'hFFFF;
`endif
    return ch;
  endfunction

  function automatic logic [15:0] actualOf(input int kind);
    case (kind)
      K_X:     return {9'd0, x};
      K_Y:     return {9'd0, y};
      K_PIX:   return pixel_data;
      K_ACT:   return {14'd0, active_ch};
      K_FCNT:  return {8'd0, frame_count};
      default: return {15'd0, sync_err};
    endcase
  endfunction

  // Monitor: outputs are stable mid-cycle, so every queued expectation is resolved on negedge
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_item   = sb.pop_front();
      mon_actual = actualOf(mon_item.kind);
      checks++;
      if (mon_actual !== mon_item.exp) begin
        failures++;
        $display("[TB] FAIL %s: got %0h expected %0h", mon_item.name, mon_actual, mon_item.exp);
      end
    end
  end

  task automatic checkOutput(input string name, input int kind, input logic [15:0] exp);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic fb, input logic sp, input int idx);
    frame_begin  = fb;
    sample_pixel = sp;
    pixel_index  = IDX_W'(idx);
    @(posedge clk); #1;
    frame_begin  = 1'b0;
    sample_pixel = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset while pulses are active
    reset = 1'b1; frame_begin = 1'b1; sample_pixel = 1'b1; sel = 2'd2;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_x", K_X, 0);
    checkOutput("rst_y", K_Y, 0);
    checkOutput("rst_pix", K_PIX, 0);
    checkOutput("rst_act", K_ACT, 0);
    checkOutput("rst_fcnt", K_FCNT, 0);
    checkOutput("rst_err", K_ERR, 0);
    idleCycle();
    reset = 1'b0; frame_begin = 1'b0; sample_pixel = 1'b0; sel = 2'd0;
    idleCycle();

    // Full frame scan with matching pixel_index
    applyStimulus(1'b1, 1'b0, 0);
    checkOutput("fb1_fcnt", K_FCNT, 1);
    checkOutput("fb1_act", K_ACT, 0);
    for (int i = 0; i < 6144; i++) begin
      applyStimulus(1'b0, 1'b1, i);
      case (i + 1)
        1: begin
          checkOutput("p1_x", K_X, 1);
          checkOutput("p1_y", K_Y, 0);
        end
        96: begin
          checkOutput("p96_x", K_X, 0);
          checkOutput("p96_y", K_Y, 1);
          checkOutput("p96_err", K_ERR, 0);
          idleCycle();
          checkOutput("pix_0_1", K_PIX, expPix(0, 1, 16'h001F));
        end
        485: begin
          checkOutput("p485_x", K_X, 5);
          checkOutput("p485_y", K_Y, 5);
          idleCycle();
          checkOutput("pix_5_5", K_PIX, expPix(5, 5, 16'h001F));
        end
        960: begin
          checkOutput("p960_y", K_Y, 10);
          idleCycle();
          checkOutput("pix_0_10", K_PIX, expPix(0, 10, 16'h001F));
        end
        6143: begin
          checkOutput("p6143_x", K_X, 95);
          checkOutput("p6143_y", K_Y, 63);
          idleCycle();
          checkOutput("pix_95_63", K_PIX, expPix(95, 63, 16'h001F));
        end
        6144: begin
          checkOutput("wrap_x", K_X, 0);
          checkOutput("wrap_y", K_Y, 0);
          checkOutput("wrap_err", K_ERR, 0);
        end
        default: ;
      endcase
    end

    // Mid-frame select change waits for the next frame
    sel = 2'd2;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, i);
    checkOutput("mid_act", K_ACT, 0);
    idleCycle();
    checkOutput("mid_pix", K_PIX, expPix(3, 0, 16'h001F));
    applyStimulus(1'b1, 1'b0, 0);
    checkOutput("fb2_act", K_ACT, 2);
    checkOutput("fb2_fcnt", K_FCNT, 2);
    for (int i = 0; i < 485; i++) applyStimulus(1'b0, 1'b1, i);
    idleCycle();
    checkOutput("ch2_pix", K_PIX, expPix(5, 5, 16'hF800));

    // Out-of-range select, with a coincident sample_pixel that must be ignored
    sel = 2'd3;
    applyStimulus(1'b1, 1'b1, 999);
    checkOutput("bad_sel_act", K_ACT, 2);
    checkOutput("bad_sel_fcnt", K_FCNT, 3);
    checkOutput("prio_x", K_X, 0);
    checkOutput("prio_y", K_Y, 0);
    checkOutput("prio_err", K_ERR, 0);

    // Index mismatch sets the sticky error
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, i);
    checkOutput("pre_err", K_ERR, 0);
    applyStimulus(1'b0, 1'b1, 100);
    checkOutput("inj_err", K_ERR, 1);
    applyStimulus(1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, i);
    checkOutput("sticky_err", K_ERR, 1);
    checkOutput("fb4_fcnt", K_FCNT, 4);

    // Frame counter wraps modulo 256
    for (int i = 0; i < 252; i++) applyStimulus(1'b1, 1'b0, 0);
    checkOutput("fcnt_wrap", K_FCNT, 0);
    checkOutput("fcnt_wrap_act", K_ACT, 2);

    // Mid-frame reset clears everything; next frame restarts cleanly
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, i);
    reset = 1'b1;
    idleCycle();
    checkOutput("mrst_x", K_X, 0);
    checkOutput("mrst_act", K_ACT, 0);
    checkOutput("mrst_fcnt", K_FCNT, 0);
    checkOutput("mrst_err", K_ERR, 0);
    reset = 1'b0;
    sel = 2'd1;
    applyStimulus(1'b1, 1'b0, 0);
    checkOutput("post_act", K_ACT, 1);
    checkOutput("post_fcnt", K_FCNT, 1);
    idleCycle();
    checkOutput("post_pix", K_PIX, expPix(0, 0, 16'h07E0));

    // Let the monitor drain, bounded
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain: pending %0d expected 0", sb.size());
    end
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
